// File: rtl/db_mem_dump.sv
// db_mem_dump: debug initiator that stalls the pipeline, sweeps data memory through
// the MEM-stage debug port and streams each word MSB-first as bytes to the UART.
module db_mem_dump #(
   parameter int MEM_WORDS = 64,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [31:0]       mem_data,
   input  logic              tx_ready,
   output logic [ADDR_W-1:0] db_dir_mem,
   output logic              db_lector,
   output logic              db_stall,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   output logic              busy,
   output logic              done
);
   localparam int CW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   typedef enum logic [2:0] {IDLE, ADDR, LATCH, SEND, DONE} state_t;
   state_t        state;
   logic [CW-1:0] word_cnt;
   logic [1:0]    byte_cnt;
   logic [31:0]   shift_reg;
   logic          last_word;
   assign last_word = word_cnt == CW'(MEM_WORDS - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         word_cnt   <= '0;
         byte_cnt   <= '0;
         shift_reg  <= '0;
         db_dir_mem <= '0;
         db_lector  <= 1'b0;
         db_stall   <= 1'b0;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state      <= ADDR;
                  word_cnt   <= '0;
                  db_dir_mem <= '0;
                  db_lector  <= 1'b1;
                  db_stall   <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            ADDR: state <= LATCH;
            LATCH: begin
               state     <= SEND;
               shift_reg <= mem_data;
               tx_data   <= mem_data[31:24];
               tx_valid  <= 1'b1;
               byte_cnt  <= '0;
            end
            SEND: if (tx_ready) begin
               // tx_data is registered, so it is preloaded with the next byte on acceptance
               if (byte_cnt != 2'd3) begin
                  byte_cnt  <= byte_cnt + 2'd1;
                  shift_reg <= {shift_reg[23:0], 8'h00};
                  tx_data   <= shift_reg[23:16];
               end else begin
                  tx_valid <= 1'b0;
                  tx_data  <= '0;
                  if (last_word) begin
                     state      <= DONE;
                     done       <= 1'b1;
                     db_lector  <= 1'b0;
                     db_stall   <= 1'b0;
                     db_dir_mem <= '0;
                  end else begin
                     state      <= ADDR;
                     word_cnt   <= word_cnt + CW'(1);
                     db_dir_mem <= ADDR_W'(word_cnt + CW'(1));
                  end
               end
            end
            DONE: begin
               state    <= IDLE;
               done     <= 1'b0;
               busy     <= 1'b0;
               word_cnt <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
